// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
// Contents: FSM state encoding, default watchdog limit, grant index width,
// and a wrap-aware index increment used for the round-robin pointer.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_HOLD      = 2'd3
    } arb_state_e;

    localparam int DEF_TIMEOUT_CYC = 65536;
    localparam int GRANT_W         = 3;

    // Successor of idx within 0..n-1. The wrap is an explicit compare so that
    // a non-power-of-two requester count never lands on an unused index.
    function automatic logic [GRANT_W-1:0] next_idx(input logic [GRANT_W-1:0] idx,
                                                    input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// rtl/rr_priority_sel.sv - combinational round-robin picker
// Ports:
//   req_i   : request vector
//   ptr_i   : index that has highest priority this cycle (0..NUM_REQ-1)
//   grant_o : one-hot winner, zero when nothing requests
//   idx_o   : binary index of the winner
//   any_o   : at least one request is present
module rr_priority_sel
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [GRANT_W-1:0] idx_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;

    // Rotating the doubled vector puts the pointer's requester at bit 0, so the
    // lowest set bit of req_rot is the winner's distance from the pointer.
    assign req_dbl = {req_i, req_i};
    assign req_rot = NUM_REQ'(req_dbl >> ptr_i);

    always_comb begin
        int pos;
        any_o   = 1'b0;
        idx_o   = '0;
        grant_o = '0;
        pos     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                any_o = 1'b1;
                pos   = int'(ptr_i) + k;
            end
        end
        if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
        end
        idx_o = GRANT_W'(pos);
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_o[i] = any_o && (idx_o == GRANT_W'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of one UART transmitter
// Optional watchdog: define UART_ARB_TIMEOUT_EN to add TIMEOUT_CYC and timeout_err.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   req_valid/data/last    : per-requester byte offer (byte i at req_data[i*8 +: 8])
//   req_ready              : one-hot accept, combinational
//   tx_data, tx_start      : registered byte and start pulse to the transmitter
//   tx_busy, tx_done       : transmitter status
//   grant_valid, grant_id  : current packet owner
//   timeout_err            : watchdog pulse (watchdog build only)
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    input  logic                        tx_done,
    output logic                        grant_valid,
    output logic [GRANT_W-1:0]          grant_id
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                        timeout_err
`endif
);

    arb_state_e          state_q;
    logic [GRANT_W-1:0]  rr_ptr_q;
    logic [GRANT_W-1:0]  grant_id_q;
    logic                grant_valid_q;
    logic                last_flag_q;
    logic [DATA_W-1:0]   tx_data_q;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [GRANT_W-1:0]  pick_idx;
    logic                pick_any;

    logic [GRANT_W-1:0]  ld_idx;
    logic [DATA_W-1:0]   ld_data;
    logic                ld_last;
    logic                accept;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0]    cnt_q;
    logic                timeout_err_q;
`endif

    rr_priority_sel #(
        .NUM_REQ(NUM_REQ)
    ) u_sel (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // In HOLD only the packet owner may be accepted; in IDLE the picker decides.
    always_comb begin
        ld_idx    = pick_idx;
        ld_data   = '0;
        ld_last   = 1'b0;
        req_ready = '0;
        accept    = 1'b0;
        if (state_q == ST_HOLD) begin
            ld_idx = grant_id_q;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GRANT_W'(i) == ld_idx) begin
                ld_data = req_data[i*DATA_W +: DATA_W];
                ld_last = req_last[i];
            end
        end
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    accept    = pick_any;
                    req_ready = pick_grant;
                end
                ST_HOLD: begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (GRANT_W'(i) == grant_id_q && req_valid[i]) begin
                            req_ready[i] = 1'b1;
                            accept       = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            tx_data_q     <= '0;
            last_flag_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        tx_data_q     <= ld_data;
                        last_flag_q   <= ld_last;
                        grant_id_q    <= ld_idx;
                        grant_valid_q <= 1'b1;
                        state_q       <= ST_START;
                    end
                end
                ST_START: begin
                    if (!tx_busy) begin
                        state_q <= ST_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        if (last_flag_q) begin
                            rr_ptr_q      <= next_idx(grant_id_q, NUM_REQ);
                            grant_valid_q <= 1'b0;
                            state_q       <= ST_IDLE;
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // A late tx_done on the limit cycle takes the branch above.
                    else if (cnt_q == CNT_LIMIT) begin
                        timeout_err_q <= 1'b1;
                        grant_valid_q <= 1'b0;
                        rr_ptr_q      <= next_idx(grant_id_q, NUM_REQ);
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_start    = (state_q == ST_START) && !tx_busy;
    assign tx_data     = tx_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (byte-level start/busy/done interface) among NUM_REQ byte producers, using round-robin arbitration.
- Each requester offers bytes with a valid/ready handshake and marks the last byte of a packet.
- The grant is held until that last byte has been transmitted, so packets from different requesters never interleave on the line.
- Sits between command/response logic and the transmitter, sharing its baud-tick domain clock.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; fixed at 8 for the UART
TIMEOUT_CYC, 65536, watchdog limit in clk cycles (used only when UART_ARB_TIMEOUT_EN is defined)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*DATA_W  per-requester byte; requester i uses bits [i*8+7:i*8]
req_last  input  NUM_REQ  byte is the last of its packet
req_ready  output  NUM_REQ  one-hot accept pulse
tx_data  output  8  byte to transmitter, registered
tx_start  output  1  one-cycle start pulse to transmitter
tx_busy  input  1  transmitter is shifting
tx_done  input  1  one-cycle pulse when the stop bit completes
grant_valid  output  1  a packet currently owns the transmitter
grant_id  output  3  index of the owner; valid when grant_valid=1
timeout_err  output  1  one-cycle pulse; port exists only with UART_ARB_TIMEOUT_EN

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, grant_valid=0, tx_data=0, tx_start=0, req_ready=0, last_flag=0, timeout_err=0. Reset mid-packet aborts the packet; the transmitter is not informed.
- States: IDLE, START, WAIT_DONE, HOLD.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - If a winner exists in the same cycle: req_ready[winner]=1, tx_data<=byte, last_flag<=req_last[winner], grant_id<=winner, grant_valid<=1, then go to START.
- START:
  - tx_start=1 only while tx_busy=0, decoded from state.
  - When tx_start=1, go to WAIT_DONE the next cycle.
  - If tx_busy=1, stay in START with no pulse.
- WAIT_DONE: on tx_done:
  - last_flag=1: rr_ptr<=(grant_id+1) mod NUM_REQ, grant_valid<=0, go to IDLE.
  - Otherwise go to HOLD.
- HOLD:
  - Only the owner is considered. Other requesters' req_ready stays 0 regardless of their valid.
  - When req_valid[grant_id]=1: req_ready pulse, load tx_data/last_flag, go to START.
- Latency:
  - Accept at cycle N gives tx_start at N+1 when tx_busy=0.
  - tx_done at M gives the next owner-byte accept at M+1 at the earliest, and tx_start at M+2.
- req_ready is combinational from state, rr_ptr and req_valid. Requesters must hold valid/data/last until ready; dropping valid early is a protocol violation with undefined result.
- Simultaneous events: tx_done and new valids in the same cycle are handled as above; new requests are seen the following cycle.
- All requests valid with all single-byte packets gives service order rr_ptr, rr_ptr+1, ... (fair rotation).
- NUM_REQ not a power of two: the wrap compare is explicit, not bit truncation.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entering WAIT_DONE and increments each cycle there.
  - On reaching TIMEOUT_CYC-1 without tx_done: timeout_err pulses 1 cycle, grant_valid<=0, rr_ptr advances past the owner, go to IDLE.
  - The remaining bytes of the owner's packet are then arbitrated as a new packet.
  - tx_done arriving on the limit cycle wins, with no error.
- Undefined: the arbiter waits indefinitely; no counter and no timeout_err port.

Decomposition:
- Package uart_arb_pkg: state encodings (IDLE=0, START=1, WAIT_DONE=2, HOLD=3), default TIMEOUT_CYC, grant_id width constant.
- Sub-module rr_priority_sel: combinational round-robin picker. Inputs: req vector and pointer. Outputs: one-hot grant, binary index, any_valid.

Test Plan:
- Single requester: req 2 sends 0xA5 with last=1, tx_busy=0 -> req_ready[2] at cycle N, tx_start at N+1 with tx_data=0xA5; after tx_done, grant_valid=0 and rr_ptr=3.
- Packet lock: req 0 sends 3-byte packet 0x11,0x22,0x33 while req 1 holds valid with 0x44 -> line order 0x11,0x22,0x33,0x44; req_ready[1] stays 0 until after 0x33's tx_done.
- Fairness: all 4 requesters valid with 1-byte packets from reset -> grant order 0,1,2,3,0; each req_ready exactly once per round.
- Transmitter busy: enter START with tx_busy=1 for 5 cycles -> no tx_start during those cycles; a single tx_start pulse on the first cycle busy drops.
- Reset mid-packet: assert reset in HOLD of req 3 -> all outputs return to reset values; the next request from req 1 is granted first (rr_ptr=0 scan).
- Timeout (macro on, TIMEOUT_CYC=16): withhold tx_done -> timeout_err pulse 16 cycles after entering WAIT_DONE, grant_valid=0, next requester served.
